universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
//
// PURPOSE
//   Parametrised N-bit universal shift register; next generation of the plain PIPO register.
//   Per-cycle mode select: hold, shift right, shift left or parallel load.
//   Shift counter flags each completed N-bit serial word, so the block works as SIPO/PISO converter.
//   Sits between serial links and parallel datapaths in the lab designs.
//
// PARAMETERS
//   N      4               register width in bits; legal range N >= 2
//   CNT_W  $clog2(N+1)     width of internal shift counter (derived; not overridden)
//
// PORTS
//   clk        in   1   clock; all state updates on posedge
//   rst_n      in   1   synchronous, active-low reset
//   mode       in   2   operation select (see BEHAVIOUR)
//   d          in   N   parallel load data
//   sin_r      in   1   serial input entering MSB on shift right
//   sin_l      in   1   serial input entering LSB on shift left
//   rotate     in   1   present only with ROTATE_EN (see CONFIGURATION)
//   q          out  N   parallel register contents
//   so_r       out  1   serial out, right shift = q[0] (combinational from q)
//   so_l       out  1   serial out, left shift = q[N-1] (combinational from q)
//   word_done  out  1   registered one-cycle pulse after each N-th shift since last load/reset
//
// BEHAVIOUR
//   - Reset: posedge clk with rst_n=0 -> q=0, cnt=0, word_done=0. Overrides any mode.
//   - mode 2'b00 HOLD: q unchanged; cnt unchanged; word_done=0.
//   - mode 2'b01 SHR:  q <= {sin_r, q[N-1:1]}.
//   - mode 2'b10 SHL:  q <= {q[N-2:0], sin_l}.
//   - mode 2'b11 LOAD: q <= d; cnt <= 0; word_done <= 0.
//   - Latency: one clock edge for every mode; q reflects the new value after that edge.
//   - Counter: each SHR/SHL edge increments cnt.
//       - If cnt==N-1 at a shift edge: cnt wraps to 0 and word_done=1 for that cycle only.
//       - All other edges drive word_done=0.
//   - SHR and SHL advance the same counter.
//   - Mixing directions within one word is legal; done still fires on the N-th shift.
//   - Reset mid-word discards partial count.
//   - Back-to-back words: continuous shifting pulses word_done every N cycles, no gap.
//   - LOAD in the cycle after word_done is legal.
//   - Inputs sampled only at posedge; no combinational path from inputs to q or word_done.
//
// CONFIGURATION
//   ROTATE_EN defined:
//     - Adds input port rotate.
//     - With rotate=1, SHR feeds q[0] into MSB and SHL feeds q[N-1] into LSB.
//     - sin_r/sin_l are ignored; counter and word_done behave as for a normal shift.
//     - With rotate=0, behaviour is identical to the build without the macro.
//   ROTATE_EN undefined:
//     - No rotate port.
//     - Shifts always take sin_r/sin_l.
//
// STRUCTURE
//   shift_pkg:
//     - mode localparams MODE_HOLD=2'b00, MODE_SHR=2'b01, MODE_SHL=2'b10, MODE_LOAD=2'b11.
//     - Shared by RTL and bench.
//   Sub-module shift_word_counter (params N, CNT_W):
//     - inputs clk, rst_n, shift_en, clear.
//     - output word_done.
//     - owns cnt and the wrap/pulse logic.
//   Top level holds the q register, next-state mux and ROTATE_EN gating.
//
// TESTING  (N=4)
//   1. Reset priority: rst_n=0, mode=LOAD, d=4'hF, one edge -> q=4'h0, word_done=0.
//   2. Load/hold: LOAD d=4'b1100 -> q=1100; HOLD 3 cycles -> q stays 1100, word_done stays 0.
//   3. Shift right: from 1100, SHR with sin_r=1,0 -> q=1110 then 0111; so_r=0,0,1 across the sequence.
//   4. Word done (SIPO):
//        - from LOAD 0, SHL with sin_l=1,0,1,1 -> q=1011 after 4th edge.
//        - word_done=1 that cycle only, 0 on the next edge.
//        - 4 further shifts -> second pulse exactly 4 cycles later.
//   5. Reset mid-word: 2 shifts, rst_n=0 one edge, then shifts.
//        - word_done only after 4 post-reset shifts.
//        - LOAD after 3 shifts also restarts the count.
//   6. ROTATE_EN build: LOAD 1000, rotate=1, sin_r=1, 4x SHR.
//        - q=0100, 0010, 0001, 1000.
//        - word_done=1 on the 4th edge.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the universal shift register and its bench.
package shift_pkg;

  localparam int unsigned MODE_W = 2;

  localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
  localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
  localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
  localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_word_counter.sv
// Counts shifts since the last load/reset and pulses word_done on every N-th shift.
module shift_word_counter #(
  parameter int unsigned N     = 4,
  parameter int unsigned CNT_W = $clog2(N + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_en,
  input  logic clear,
  output logic word_done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  logic [CNT_W-1:0] cnt;

  // Counter and one-cycle done pulse; any non-shifting edge drops the pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else if (clear) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else if (shift_en) begin
      if (cnt == CNT_LAST) begin
        cnt       <= '0;
        word_done <= 1'b1;
      end else begin
        cnt       <= cnt + CNT_W'(1);
        word_done <= 1'b0;
      end
    end else begin
      word_done <= 1'b0;
    end
  end

endmodule

// File: rtl/universal_shift_reg.sv
// N-bit universal shift register: hold / shift right / shift left / load,
// with a word counter for SIPO/PISO use.
// Optional macro ROTATE_EN adds a rotate input that recirculates the
// outgoing bit instead of taking sin_r/sin_l.
module universal_shift_reg
  import shift_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [MODE_W-1:0] mode,
  input  logic [N-1:0]      d,
  input  logic              sin_r,
  input  logic              sin_l,
`ifdef ROTATE_EN
  input  logic              rotate,
`endif
  output logic [N-1:0]      q,
  output logic              so_r,
  output logic              so_l,
  output logic              word_done
);

  localparam int unsigned CNT_W = $clog2(N + 1);

  logic [N-1:0] q_nxt;
  logic         fill_r;
  logic         fill_l;
  logic         shift_en;
  logic         clear;

  // Select the bit entering the register on each shift direction.
  always_comb begin
    fill_r = sin_r;
    fill_l = sin_l;
`ifdef ROTATE_EN
    if (rotate) begin
      fill_r = q[0];
      fill_l = q[N-1];
    end
`endif
  end

  // Next-state mux and counter controls per mode.
  always_comb begin
    q_nxt    = q;
    shift_en = 1'b0;
    clear    = 1'b0;
    case (mode)
      MODE_SHR: begin
        q_nxt    = {fill_r, q[N-1:1]};
        shift_en = 1'b1;
      end
      MODE_SHL: begin
        q_nxt    = {q[N-2:0], fill_l};
        shift_en = 1'b1;
      end
      MODE_LOAD: begin
        q_nxt = d;
        clear = 1'b1;
      end
      default: q_nxt = q;
    endcase
  end

  // Register contents; reset overrides every mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q <= '0;
    end else begin
      q <= q_nxt;
    end
  end

  assign so_r = q[0];
  assign so_l = q[N-1];

  shift_word_counter #(
    .N     (N),
    .CNT_W (CNT_W)
  ) u_counter (
    .clk       (clk),
    .rst_n     (rst_n),
    .shift_en  (shift_en),
    .clear     (clear),
    .word_done (word_done)
  );

endmodule

// File: tb/tb_universal_shift_reg.sv
// Bench for universal_shift_reg: directed steps plus random traffic against
// an arithmetic reference model. Honours ROTATE_EN when defined.
module tb_universal_shift_reg;
  import shift_pkg::*;

  localparam int unsigned N = 4;
`ifdef ROTATE_EN
  localparam bit ROT = 1'b1;
`else
  localparam bit ROT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic [MODE_W-1:0] mode;
  logic [N-1:0]      d;
  logic              sin_r;
  logic              sin_l;
  logic              rotate;
  logic [N-1:0]      q;
  logic              so_r;
  logic              so_l;
  logic              word_done;

  int checks   = 0;
  int failures = 0;

  // Reference model: register value as an integer, shifts since last load/reset.
  int unsigned m_q     = 0;
  int unsigned m_shift = 0;
  bit          m_done  = 1'b0;

  always #5 clk = ~clk;

  universal_shift_reg #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .d         (d),
    .sin_r     (sin_r),
    .sin_l     (sin_l),
`ifdef ROTATE_EN
    .rotate    (rotate),
`endif
    .q         (q),
    .so_r      (so_r),
    .so_l      (so_l),
    .word_done (word_done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_shift();
    m_shift++;
    if (m_shift == N) begin
      m_shift = 0;
      m_done  = 1'b1;
    end else begin
      m_done = 1'b0;
    end
  endtask

  // One clock: drive on negedge, update model at posedge, compare just after.
  task automatic step(input logic r, input logic [1:0] m, input logic [N-1:0] dd,
                      input logic sr, input logic sl, input logic rot);
    int unsigned bit_in;
    int unsigned full;
    full = (1 << N) - 1;
    @(negedge clk);
    rst_n  = r;
    mode   = m;
    d      = dd;
    sin_r  = sr;
    sin_l  = sl;
    rotate = rot;
    @(posedge clk);
    if (!r) begin
      m_q = 0; m_shift = 0; m_done = 1'b0;
    end else begin
      case (m)
        MODE_HOLD: m_done = 1'b0;
        MODE_SHR: begin
          bit_in = (ROT && rot) ? (m_q % 2) : int'(sr);
          m_q = (m_q / 2) + bit_in * (1 << (N - 1));
          model_shift();
        end
        MODE_SHL: begin
          bit_in = (ROT && rot) ? (m_q / (1 << (N - 1))) : int'(sl);
          m_q = (m_q * 2 + bit_in) & full;
          model_shift();
        end
        default: begin
          m_q = int'(dd); m_shift = 0; m_done = 1'b0;
        end
      endcase
    end
    #1;
    chk("q", 32'(q), m_q);
    chk("word_done", 32'(word_done), 32'(m_done));
    chk("so_r", 32'(so_r), m_q % 2);
    chk("so_l", 32'(so_l), m_q / (1 << (N - 1)));
  endtask

  initial begin
    rst_n = 1'b0; mode = MODE_HOLD; d = '0; sin_r = 1'b0; sin_l = 1'b0; rotate = 1'b0;

    // Reset priority over LOAD
    step(1'b0, MODE_LOAD, 4'hF, 1'b0, 1'b0, 1'b0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_done", 32'(word_done), 32'h0);

    // Load and hold
    step(1'b1, MODE_LOAD, 4'b1100, 1'b0, 1'b0, 1'b0);
    chk("load_q", 32'(q), 32'hC);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, MODE_HOLD, 4'h0, 1'b1, 1'b1, 1'b0);
      chk("hold_q", 32'(q), 32'hC);
      chk("hold_done", 32'(word_done), 32'h0);
    end

    // Shift right with serial 1 then 0
    chk("shr_so_r0", 32'(so_r), 32'h0);
    step(1'b1, MODE_SHR, 4'h0, 1'b1, 1'b0, 1'b0);
    chk("shr_q1", 32'(q), 32'hE);
    chk("shr_so_r1", 32'(so_r), 32'h0);
    step(1'b1, MODE_SHR, 4'h0, 1'b0, 1'b0, 1'b0);
    chk("shr_q2", 32'(q), 32'h7);
    chk("shr_so_r2", 32'(so_r), 32'h1);

    // SIPO word: 1,0,1,1 on sin_l, then a second word back to back
    step(1'b1, MODE_LOAD, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("sipo_pre_done", 32'(word_done), 32'h0);
    step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
    chk("sipo_q", 32'(q), 32'hB);
    chk("sipo_done1", 32'(word_done), 32'h1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, (i % 2 == 0) ? MODE_SHR : MODE_SHL, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("sipo_done2", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
    end
    // Load right after a pulse
    step(1'b1, MODE_LOAD, 4'h5, 1'b0, 1'b0, 1'b0);
    chk("load_after_done", 32'(q), 32'h5);

    // Reset mid-word discards the partial count
    step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
    step(1'b0, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, MODE_SHR, 4'h0, 1'b1, 1'b0, 1'b0);
      chk("rst_mid_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
    end

    // Load after three shifts restarts the count
    for (int i = 0; i < 3; i++) step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b0, 1'b0);
    step(1'b1, MODE_LOAD, 4'h9, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, MODE_SHL, 4'h0, 1'b0, 1'b1, 1'b0);
      chk("load_mid_done", 32'(word_done), (i == 3) ? 32'h1 : 32'h0);
    end

`ifdef ROTATE_EN
    // Rotate right ignores sin_r
    step(1'b1, MODE_LOAD, 4'b1000, 1'b0, 1'b0, 1'b0);
    step(1'b1, MODE_SHR, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("rot_q1", 32'(q), 32'h4);
    step(1'b1, MODE_SHR, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("rot_q2", 32'(q), 32'h2);
    step(1'b1, MODE_SHR, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("rot_q3", 32'(q), 32'h1);
    step(1'b1, MODE_SHR, 4'h0, 1'b1, 1'b0, 1'b1);
    chk("rot_q4", 32'(q), 32'h8);
    chk("rot_done", 32'(word_done), 32'h1);
`endif

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 31) != 0),
           2'($urandom_range(0, 3)),
           N'($urandom),
           1'($urandom),
           1'($urandom),
           1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
